// File: rtl/fifo_rd_stream_pkg.sv
// rtl/fifo_rd_stream_pkg.sv - occupancy encoding and statistics width for fifo_rd_stream
package fifo_rd_stream_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    localparam int STAT_CW = 32;

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// rtl/fifo_rd_stream_buf.sv - two-entry head/tail data register pair
module fifo_rd_stream_buf #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              load_head,
    input  logic              load_tail,
    input  logic              shift,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] head
);

    logic [DWIDTH-1:0] head_q;
    logic [DWIDTH-1:0] tail_q;

    // Entries are data-only and deliberately not reset; occupancy lives in the top.
    always_ff @(posedge clk) begin
        if (load_head) begin
            head_q <= din;
        end else if (shift) begin
            head_q <= tail_q;
        end
        if (load_tail) begin
            tail_q <= din;
        end
    end

    assign head = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read port to valid/ready stream adapter; FIFO_RD_STREAM_STAT_EN adds beat_cnt/stall
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              fifo_read,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_STAT_EN
    ,
    output logic [STAT_CW-1:0] beat_cnt,
    output logic               stall
`endif
);

    occ_e       occ_q;
    occ_e       occ_d;
    logic       inflight_q;
    logic       pop;
    logic [1:0] occ_after_pop;
    logic [1:0] level;
    logic       load_head;
    logic       load_tail;
    logic       shift;

    // m_ready reaches fifo_read combinationally so a pop frees a slot in the same cycle.
    always_comb begin
        m_valid       = (occ_q != EMPTY);
        pop           = m_valid & m_ready;
        occ_after_pop = occ_q - {1'b0, pop};
        level         = occ_after_pop + {1'b0, inflight_q};
        fifo_read     = !rst && !fifo_empty && (level < 2'd2);
        load_head     = inflight_q && (occ_after_pop == 2'd0);
        load_tail     = inflight_q && (occ_after_pop != 2'd0);
        shift         = pop && (occ_q == TWO);
        occ_d         = occ_e'(level);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= EMPTY;
            inflight_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_read;
        end
    end

    fifo_rd_stream_buf #(
        .DWIDTH(DWIDTH)
    ) u_buf (
        .clk      (clk),
        .load_head(load_head),
        .load_tail(load_tail),
        .shift    (shift),
        .din      (fifo_dout),
        .head     (m_data)
    );

`ifdef FIFO_RD_STREAM_STAT_EN
    logic [STAT_CW-1:0] beat_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
        end else if (pop) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
        end
    end

    assign beat_cnt = beat_cnt_q;
    assign stall    = m_valid & !m_ready;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream with a queue-based FIFO and scoreboard
module tb_fifo_rd_stream;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_read;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
`ifdef FIFO_RD_STREAM_STAT_EN
    logic [31:0]   beat_cnt;
    logic          stall;
`endif

    int checks = 0;
    int failures = 0;
    int bad_reads = 0;

    logic [DW-1:0] push_req[$];
    logic [DW-1:0] fifo_q[$];
    int            taken = 0;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DWIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_read (fifo_read),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data)
`ifdef FIFO_RD_STREAM_STAT_EN
        ,
        .beat_cnt  (beat_cnt),
        .stall     (stall)
`endif
    );

    // Behavioural synchronous FIFO: registered dout one cycle after read, writes visible next cycle.
    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
            taken = push_req.size();
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_read) begin
                if (fifo_q.size() == 0) bad_reads++;
                else fifo_dout <= fifo_q.pop_front();
            end
            while (taken < push_req.size()) begin
                fifo_q.push_back(push_req[taken]);
                taken++;
            end
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          push;
        logic [DW-1:0] val;
        logic          ready;
        logic          exp_read;
        logic          exp_valid;
        logic          chk_data;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] prev_data;
        logic          prev_stall;
        int            reads;
        int            got;
        int            sent;
        int            cyc;
        int            read_while_empty;

        vecs[0] = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h11};
        vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_read", {31'b0, fifo_read}, 32'd0);
        check("rst_valid", {31'b0, m_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single word, table driven
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (vecs[i].push) push_req.push_back(vecs[i].val);
            m_ready = vecs[i].ready;
            #1;
            check($sformatf("t1_read[%0d]", i), {31'b0, fifo_read}, {31'b0, vecs[i].exp_read});
            check($sformatf("t1_valid[%0d]", i), {31'b0, m_valid}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].chk_data) check($sformatf("t1_data[%0d]", i), m_data, vecs[i].exp_data);
        end

        // Eight words back to back, no bubbles
        @(negedge clk);
        for (int i = 0; i < 8; i++) push_req.push_back(i);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            m_ready = 1'b1;
            #1;
            check($sformatf("t2_read[%0d]", c), {31'b0, fifo_read}, {31'b0, (c < 8)});
            check($sformatf("t2_valid[%0d]", c), {31'b0, m_valid}, {31'b0, (c >= 2 && c < 10)});
            if (c >= 2 && c < 10) check($sformatf("t2_data[%0d]", c), m_data, c - 2);
        end

        // Backpressure: only two reads issued, head held stable
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_req.push_back(32'h100 + i);
        reads = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (fifo_read) reads++;
            if (c >= 2) check($sformatf("t3_hold[%0d]", c), m_data, 32'h100);
        end
        check("t3_reads", reads, 2);
        check("t3_valid", {31'b0, m_valid}, 32'd1);
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            m_ready = 1'b1;
            #1;
            if (m_valid) begin
                check($sformatf("t3_data[%0d]", got), m_data, 32'h100 + got);
                got++;
            end
        end
        check("t3_count", got, 4);

        // Random fill and random backpressure against a scoreboard
        sent = 0;
        got = 0;
        cyc = 0;
        read_while_empty = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        while (got < 200 && cyc < 5000) begin
            logic [DW-1:0] w;
            @(negedge clk);
            cyc++;
            if (sent < 200 && ($urandom % 4) != 0) begin
                w = $urandom;
                push_req.push_back(w);
                exp_q.push_back(w);
                sent++;
            end
            m_ready = $urandom % 2;
            #1;
            if (fifo_read && fifo_empty) read_while_empty++;
            if (prev_stall) begin
                check("rnd_hold_valid", {31'b0, m_valid}, 32'd1);
                check("rnd_hold_data", m_data, prev_data);
            end
`ifdef FIFO_RD_STREAM_STAT_EN
            check("rnd_stall", {31'b0, stall}, {31'b0, (m_valid & !m_ready)});
`endif
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_extra_beat", m_data, 32'hDEAD_BEEF);
                end else begin
                    check("rnd_data", m_data, exp_q.pop_front());
                end
                got++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
        end
        check("rnd_received", got, 200);
        check("rnd_read_empty", read_while_empty, 0);
        check("rnd_bad_reads", bad_reads, 0);

        // Reset mid-operation with a full buffer
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_req.push_back(32'h200 + i);
        repeat (4) @(negedge clk);
        #1;
        check("rs_full_valid", {31'b0, m_valid}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        m_ready = 1'b1;
        #1;
        check("rs_read_in_rst", {31'b0, fifo_read}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rs_valid_after", {31'b0, m_valid}, 32'd0);
        check("rs_read_after", {31'b0, fifo_read}, 32'd0);
        @(negedge clk);
        push_req.push_back(32'hAA);
        got = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (m_valid) begin
                check("rs_first_data", m_data, (got == 0) ? 32'hAA : 32'hBAD0_BAD0);
                got++;
            end
        end
        check("rs_count", got, 1);

`ifdef FIFO_RD_STREAM_STAT_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("st_cnt_rst", beat_cnt, 32'd0);
        for (int i = 0; i < 10; i++) push_req.push_back(i);
        repeat (16) @(negedge clk);
        #1;
        check("st_cnt_10", beat_cnt, 32'd10);
        force dut.beat_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.beat_cnt_q;
        for (int i = 0; i < 3; i++) push_req.push_back(i);
        repeat (10) @(negedge clk);
        #1;
        check("st_cnt_wrap", beat_cnt, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
